// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - merges pipeline writeback and queued long-latency results onto one register file write port
//
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   pipe_we/pipe_waddr/pipe_wdata     pipeline writeback request (highest priority)
//   pipe_stall                        pipeline must hold its writeback this cycle
//   lng_valid/lng_ready/lng_waddr/lng_wdata
//                                     long-latency result handshake
//   rf_we/rf_waddr/rf_wdata           registered register file write port
//   qaddr1/qhit1/qdata1, qaddr2/qhit2/qdata2
//                                     forwarding lookups into in-flight values
module rf_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        lng_valid,
  output logic        lng_ready,
  input  logic [4:0]  lng_waddr,
  input  logic [31:0] lng_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        pipe_stall,
  input  logic [4:0]  qaddr1,
  input  logic [4:0]  qaddr2,
  output logic        qhit1,
  output logic        qhit2,
  output logic [31:0] qdata1,
  output logic [31:0] qdata2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic [SW-1:0]    starve_cnt;

  logic pipe_eff, lng_acc, lng_keep;
  logic head_vld, head_dead, any_vld;
  logic head_win, byp, enq, pop;

  assign pipe_stall = resetn && (starve_cnt == SW'(STARVE_MAX));
  assign lng_ready  = resetn && (count < (PW+1)'(DEPTH));

  assign pipe_eff  = pipe_we && (pipe_waddr != 5'd0) && !pipe_stall;
  assign lng_acc   = lng_valid && lng_ready;
  // Writes to r0 are dropped; a concurrent pipeline write to the same
  // register is younger, so the long result is dead on arrival.
  assign lng_keep  = lng_acc && (lng_waddr != 5'd0) &&
                     !(pipe_eff && (pipe_waddr == lng_waddr));
  assign head_vld  = (count != '0) && q_vld[rd_ptr];
  assign head_dead = (count != '0) && !q_vld[rd_ptr];
  assign any_vld   = |q_vld;

  assign head_win = !pipe_eff && head_vld;
  // Bypass only when no valid older entry could be overtaken.
  assign byp      = !pipe_eff && !head_vld && lng_keep && !any_vld;
  assign enq      = lng_keep && !byp;
  // Squashed heads retire without using the write port.
  assign pop      = head_win || head_dead;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      q_vld      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      rf_we <= pipe_eff || head_win || byp;
      if (pipe_eff) begin
        rf_waddr <= pipe_waddr;
        rf_wdata <= pipe_wdata;
      end else if (head_win) begin
        rf_waddr <= q_addr[rd_ptr];
        rf_wdata <= q_data[rd_ptr];
      end else if (byp) begin
        rf_waddr <= lng_waddr;
        rf_wdata <= lng_wdata;
      end

      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_eff && (q_addr[i] == pipe_waddr)) q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      // Enqueue slot never aliases the popped slot: that would need the
      // FIFO to be both full (no accept) and non-empty-empty at once.
      if (enq) begin
        q_vld[wr_ptr]  <= 1'b1;
        q_addr[wr_ptr] <= lng_waddr;
        q_data[wr_ptr] <= lng_wdata;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (head_win || !head_vld) starve_cnt <= '0;
      else if (pipe_eff)         starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Walk oldest to newest so the newest matching entry wins; the rf_*
  // register is the oldest in-flight value.
  logic [PW-1:0] age_idx;
  always_comb begin
    age_idx = '0;
    qhit1   = resetn && rf_we && (rf_waddr == qaddr1);
    qhit2   = resetn && rf_we && (rf_waddr == qaddr2);
    qdata1  = rf_wdata;
    qdata2  = rf_wdata;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = rd_ptr + PW'(i);
      if (resetn && q_vld[age_idx] && (q_addr[age_idx] == qaddr1)) begin
        qhit1  = 1'b1;
        qdata1 = q_data[age_idx];
      end
      if (resetn && q_vld[age_idx] && (q_addr[age_idx] == qaddr2)) begin
        qhit2  = 1'b1;
        qdata2 = q_data[age_idx];
      end
    end
    if (qaddr1 == 5'd0) qhit1 = 1'b0;
    if (qaddr2 == 5'd0) qhit2 = 1'b0;
    if (!qhit1) qdata1 = 32'd0;
    if (!qhit2) qdata2 = 32'd0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed vector bench for rf_write_arbiter
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        lng_valid = 1'b0;
  logic        lng_ready;
  logic [4:0]  lng_waddr = '0;
  logic [31:0] lng_wdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [4:0]  qaddr1 = '0, qaddr2 = '0;
  logic        qhit1, qhit2;
  logic [31:0] qdata1, qdata2;

  int total = 0;
  int bad   = 0;

  rf_write_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lng_valid(lng_valid), .lng_ready(lng_ready),
    .lng_waddr(lng_waddr), .lng_wdata(lng_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall),
    .qaddr1(qaddr1), .qaddr2(qaddr2),
    .qhit1(qhit1), .qhit2(qhit2), .qdata1(qdata1), .qdata2(qdata2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rn;
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_st;
    logic        e_rdy;
    logic        e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic rn, logic pwe, logic [4:0] pa, logic [31:0] pd,
                             logic lv, logic [4:0] la, logic [31:0] ld,
                             logic [4:0] q1, logic [4:0] q2,
                             logic e_we, logic [4:0] e_wa, logic [31:0] e_wd,
                             logic e_st, logic e_rdy,
                             logic e_h1, logic [31:0] e_d1, logic e_h2, logic [31:0] e_d2);
    vec_t r;
    r = '{rn, pwe, pa, pd, lv, la, ld, q1, q2,
          e_we, e_wa, e_wd, e_st, e_rdy, e_h1, e_d1, e_h2, e_d2};
    return r;
  endfunction

  task automatic check(string name, logic ok, string got, string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s want %s", name, got, want);
    end
  endtask

  logic        found;
  logic [31:0] gotd;

  initial begin
    //          rn pwe pa  pd          lv la  ld          q1  q2   we wa  wd          st rdy h1 d1          h2 d2
    vecs.push_back(v(0, 0, 0,  32'h0,      0, 0,  32'h0,      5,  0,   0, 0,  32'h0,      0, 0,  0, 32'h0,      0, 32'h0));
    vecs.push_back(v(1, 1, 5,  32'h1234,   0, 0,  32'h0,      5,  0,   1, 5,  32'h1234,   0, 1,  1, 32'h1234,   0, 32'h0));
    vecs.push_back(v(1, 1, 0,  32'hdead,   0, 0,  32'h0,      5,  0,   0, 5,  32'h1234,   0, 1,  0, 32'h0,      0, 32'h0));
    vecs.push_back(v(1, 0, 0,  32'h0,      1, 7,  32'hAA,     7,  5,   1, 7,  32'hAA,     0, 1,  1, 32'hAA,     0, 32'h0));
    vecs.push_back(v(1, 1, 1,  32'h100,    1, 2,  32'h200,    2,  1,   1, 1,  32'h100,    0, 1,  1, 32'h200,    1, 32'h100));
    vecs.push_back(v(1, 1, 1,  32'h101,    1, 3,  32'h11,     3,  2,   1, 1,  32'h101,    0, 0,  1, 32'h11,     1, 32'h200));
    vecs.push_back(v(1, 1, 3,  32'h22,     1, 4,  32'h44,     3,  4,   1, 3,  32'h22,     0, 0,  1, 32'h22,     0, 32'h0));
    vecs.push_back(v(1, 1, 6,  32'h66,     0, 0,  32'h0,      3,  2,   1, 6,  32'h66,     0, 0,  0, 32'h0,      1, 32'h200));
    vecs.push_back(v(1, 1, 6,  32'h67,     0, 0,  32'h0,      6,  2,   1, 6,  32'h67,     1, 0,  1, 32'h67,     1, 32'h200));
    vecs.push_back(v(1, 1, 8,  32'h88,     0, 0,  32'h0,      8,  3,   1, 2,  32'h200,    0, 1,  0, 32'h0,      0, 32'h0));
    vecs.push_back(v(1, 1, 8,  32'h88,     0, 0,  32'h0,      8,  3,   1, 8,  32'h88,     0, 1,  1, 32'h88,     0, 32'h0));
    vecs.push_back(v(1, 1, 9,  32'h1,      1, 9,  32'h2,      9,  0,   1, 9,  32'h1,      0, 1,  1, 32'h1,      0, 32'h0));
    vecs.push_back(v(1, 0, 0,  32'h0,      1, 10, 32'hA0,     10, 9,   1, 10, 32'hA0,     0, 1,  1, 32'hA0,     0, 32'h0));
    vecs.push_back(v(1, 1, 11, 32'hB0,     1, 0,  32'h5,      11, 0,   1, 11, 32'hB0,     0, 1,  1, 32'hB0,     0, 32'h0));
    vecs.push_back(v(1, 0, 0,  32'h0,      1, 12, 32'hC0,     12, 11,  1, 12, 32'hC0,     0, 1,  1, 32'hC0,     0, 32'h0));
    vecs.push_back(v(1, 1, 1,  32'h1,      1, 13, 32'hD0,     13, 1,   1, 1,  32'h1,      0, 1,  1, 32'hD0,     1, 32'h1));
    vecs.push_back(v(1, 1, 1,  32'h2,      1, 14, 32'hE0,     13, 14,  1, 1,  32'h2,      0, 0,  1, 32'hD0,     1, 32'hE0));
    vecs.push_back(v(0, 1, 1,  32'h3,      1, 15, 32'hF0,     13, 14,  0, 0,  32'h0,      0, 0,  0, 32'h0,      0, 32'h0));
    vecs.push_back(v(1, 0, 0,  32'h0,      0, 0,  32'h0,      13, 14,  0, 0,  32'h0,      0, 1,  0, 32'h0,      0, 32'h0));
    vecs.push_back(v(1, 0, 0,  32'h0,      1, 15, 32'hF0,     15, 13,  1, 15, 32'hF0,     0, 1,  1, 32'hF0,     0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetn     = vecs[i].rn;
      pipe_we    = vecs[i].pwe;
      pipe_waddr = vecs[i].pa;
      pipe_wdata = vecs[i].pd;
      lng_valid  = vecs[i].lv;
      lng_waddr  = vecs[i].la;
      lng_wdata  = vecs[i].ld;
      qaddr1     = vecs[i].q1;
      qaddr2     = vecs[i].q2;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {rf_we, rf_waddr, rf_wdata, pipe_stall, lng_ready, qhit1, qdata1, qhit2, qdata2} ===
            {vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_st, vecs[i].e_rdy,
             vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2},
            $sformatf("we=%0d wa=%0d wd=%h st=%0d rdy=%0d h1=%0d d1=%h h2=%0d d2=%h",
                      rf_we, rf_waddr, rf_wdata, pipe_stall, lng_ready, qhit1, qdata1, qhit2, qdata2),
            $sformatf("we=%0d wa=%0d wd=%h st=%0d rdy=%0d h1=%0d d1=%h h2=%0d d2=%h",
                      vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_st, vecs[i].e_rdy,
                      vecs[i].e_h1, vecs[i].e_d1, vecs[i].e_h2, vecs[i].e_d2));
    end

    // Continuous pipeline traffic: two long results fill the FIFO, the head
    // starves, gets forced through, then the held pipe write follows.
    @(negedge clk);
    qaddr1 = 0; qaddr2 = 0;
    pipe_we = 1; pipe_waddr = 20; pipe_wdata = 32'h2000;
    lng_valid = 1; lng_waddr = 21; lng_wdata = 32'h2100;
    @(negedge clk);
    lng_waddr = 22; lng_wdata = 32'h2200;
    @(posedge clk);
    #1;
    check("fifo_full", lng_ready === 1'b0, $sformatf("rdy=%0d", lng_ready), "rdy=0");
    @(negedge clk);
    lng_valid = 0;
    found = 0;
    gotd  = '0;
    for (int k = 0; k < 5 && !found; k++) begin
      @(posedge clk);
      #1;
      if (rf_we && rf_waddr == 5'd21) begin
        found = 1;
        gotd  = rf_wdata;
      end
    end
    check("starved_head", found && gotd == 32'h2100,
          $sformatf("found=%0d wd=%h", found, gotd), "found=1 wd=00002100");
    @(posedge clk);
    #1;
    check("pipe_after_stall", rf_we && rf_waddr == 5'd20 && rf_wdata == 32'h2000,
          $sformatf("we=%0d wa=%0d wd=%h", rf_we, rf_waddr, rf_wdata), "we=1 wa=20 wd=00002000");
    @(negedge clk);
    pipe_we = 0;
    found = 0;
    gotd  = '0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(posedge clk);
      #1;
      if (rf_we && rf_waddr == 5'd22) begin
        found = 1;
        gotd  = rf_wdata;
      end
    end
    check("drain_second", found && gotd == 32'h2200,
          $sformatf("found=%0d wd=%h", found, gotd), "found=1 wd=00002200");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-side front end for the 32×32 MIPS general register file (r0 hard-wired to zero, registers written on the rising clock edge). It merges two result producers onto the register file's single write port:
- the main pipeline writeback, one write per cycle, highest priority;
- a long-latency unit (mul/div, uncached load return), buffered in a small in-order FIFO.

It also provides two lookup ports so decode can forward in-flight values that the register file does not yet hold.

## Interface
- `DEPTH`, default 2: long-result FIFO entries; power of two, ≥2.
- `STARVE_MAX`, default 4: consecutive cycles a valid FIFO head may be denied the write port before the pipeline is stalled.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: synchronous, active-low reset.
- `pipe_we` in 1: pipeline writeback request.
- `pipe_waddr` in 5: destination register of the pipeline write.
- `pipe_wdata` in 32: data of the pipeline write.
- `lng_valid` in 1: long-latency result valid.
- `lng_ready` out 1: arbiter can accept a long-latency result.
- `lng_waddr` in 5: destination register of the long-latency result.
- `lng_wdata` in 32: data of the long-latency result.
- `rf_we` out 1: register file write enable (registered).
- `rf_waddr` out 5: register file write address (registered).
- `rf_wdata` out 32: register file write data (registered).
- `pipe_stall` out 1: pipeline must hold its writeback.
- `qaddr1` in 5, `qaddr2` in 5: forwarding lookup addresses.
- `qhit1` out 1, `qhit2` out 1: lookup hit in arbiter state.
- `qdata1` out 32, `qdata2` out 32: forwarded value; 0 when no hit.

## Operation
**Request qualification**
- A pipeline write is *effective* when `pipe_we && pipe_waddr != 0 && !pipe_stall`.
- While `pipe_stall` = 1, a pipeline request is not consumed; upstream re-presents it.
- Long handshake: the result is accepted when `lng_valid && lng_ready`.
- `lng_ready` = `resetn && count < DEPTH`. It depends on the current count only; there is no pass-through when the FIFO is full.
- An accepted long result with `lng_waddr` = 0 is discarded and takes no FIFO slot.

**Write-port arbitration** (one winner per cycle; the winner is loaded into the `rf_*` output registers):
1. Effective pipeline write.
2. Else the valid FIFO head, which is popped.
3. Else an accepted long result, when the FIFO holds no valid entries (bypass, not enqueued).
4. Else `rf_we` = 0.
- An accepted long result that does not win is enqueued at the tail.

**Squash (ordering contract)**
- The issue logic guarantees a long result is older than any pipeline write to the same register that is concurrent with or later than it.
- An effective pipeline write therefore invalidates:
  - every FIFO entry with the same `waddr`;
  - a same-cycle accepted long result with the same `waddr`, which is dropped.
- An invalid head is retired in any cycle without using the write port. It still occupies a slot until retired.

**Starvation**
- `starve_cnt` increments in each cycle where the head is valid and loses to the pipeline.
- It clears on a pop, and whenever the head is invalid or the FIFO is empty.
- `pipe_stall` = (`starve_cnt == STARVE_MAX`). This forces item 2 to win the next arbitration.

**Lookup** (per port, combinational)
- `qaddr` = 0 never hits.
- Otherwise priority is: newest valid FIFO entry, then older FIFO entries, then the `rf_*` register when `rf_we` = 1.
- The same-cycle inputs are not searched.

## Timing
- Reset values:
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0;
  - FIFO empty, `starve_cnt` = 0;
  - `pipe_stall` = 0, `lng_ready` = 0 while `resetn` = 0;
  - `qhit*` = 0, `qdata*` = 0.
- Reset mid-operation discards all queued entries.
- Pipeline write accepted in cycle N: `rf_we` = 1 in N+1. The register file holds the value from N+2; `qhit` covers N+1.
- Long result bypassed in N: `rf_we` = 1 in N+1.
- Long result queued: at least 1 cycle after the cycle in which it reaches the head unopposed.
- A pop and an enqueue in the same cycle are legal; the count is unchanged.
- A head that is continuously valid and losing is written within `STARVE_MAX` + 2 cycles.

## Test plan
- Pipe write r5 = 0x1234 in cycle 0 → `rf_we`/`rf_waddr` = 5/`rf_wdata` = 0x1234 in cycle 1; `qaddr1` = 5 gives `qhit1` = 1, `qdata1` = 0x1234 in cycle 1. Pipe write to r0 → `rf_we` stays 0.
- Idle pipe, long result r7 = 0xAA → bypass, `rf_we` in the next cycle. With `pipe_we` held continuously, two long results fill the FIFO and `lng_ready` = 0.
- FIFO holds r3 = 0x11, then pipe writes r3 = 0x22 → entry squashed; `qdata` for r3 = 0x22; r3 = 0x11 is never written.
- Pipe writes every cycle with a valid head, `STARVE_MAX` = 4 → `pipe_stall` = 1 after 4 losses. The next cycle writes the head; the pipe request is written the cycle after.
- Same-cycle pipe r9 = 1 and long r9 = 2 → only r9 = 1 is written; the FIFO count is unchanged.
- `resetn` = 0 with 2 queued entries → next cycle `rf_we` = 0, FIFO empty, `qhit*` = 0, and `lng_ready` = 1 after release.
